// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the shared
// datapath / functional units (slave). Select widths come from the
// SRCA / SRCB / ALU_OP / RESULT_WIDTH macros, with local defaults.
`ifndef SRCA
`define SRCA 2
`endif
`ifndef SRCB
`define SRCB 2
`endif
`ifndef ALU_OP
`define ALU_OP 2
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 3
`endif

interface multicycle_ctrl_fsm_if;
   logic [6:0]               op;
   logic                     funct7b1;
   logic                     Zero;
   logic                     mem_ready;
   logic                     alu_ready;
   logic                     mul_ready;
   logic                     csr_ready;
   logic                     trap_ack;

   logic                     AdrSrc;
   logic                     IRWrite;
   logic                     PCUpdate;
   logic                     Branch;
   logic                     RegWrite;
   logic                     MemWrite;
   logic [`SRCA-1:0]         ALUSrcA;
   logic [`SRCB-1:0]         ALUSrcB;
   logic [`ALU_OP-1:0]       ALUOp;
   logic [`RESULT_WIDTH-1:0] ResultSrc;
   logic [2:0]               ImmSrc;
   logic                     ALUOutWrite;
   logic                     mem_valid;
   logic                     alu_valid;
   logic                     mul_valid;
   logic                     csr_valid;
   logic                     trap_valid;
   logic [1:0]               trap_cause;

   // Sequencer side
   modport master (
      input  op, funct7b1, Zero, mem_ready, alu_ready, mul_ready, csr_ready, trap_ack,
      output AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, ALUOutWrite,
             mem_valid, alu_valid, mul_valid, csr_valid, trap_valid, trap_cause
   );

   // Datapath / unit side
   modport slave (
      output op, funct7b1, Zero, mem_ready, alu_ready, mul_ready, csr_ready, trap_ack,
      input  AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, ALUOutWrite,
             mem_valid, alu_valid, mul_valid, csr_valid, trap_valid, trap_cause
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the kianV rv32 multicycle datapath: fetch/decode/
// execute/writeback over valid/ready handshakes, CSR/system path, illegal
// opcode trap and a memory-bus stall watchdog.
// Optional M-extension path is built only when KIANV_MULDIV_EN is defined.
`ifndef SRCA
`define SRCA 2
`endif
`ifndef SRCB
`define SRCB 2
`endif
`ifndef ALU_OP
`define ALU_OP 2
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 3
`endif

module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 256,   // 0 disables the watchdog
   parameter int CSR_SUPPORT = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   multicycle_ctrl_fsm_if.master bus
);

   typedef enum logic [4:0] {
      FETCH    = 5'd0,  DECODE  = 5'd1,  MEMADDR  = 5'd2,  MEMREAD = 5'd3,
      MEMWB    = 5'd4,  MEMWRITE = 5'd5, EXEC_R   = 5'd6,  ALUWB   = 5'd7,
      EXEC_I   = 5'd8,  JAL     = 5'd9,  BRANCH   = 5'd10, JALR    = 5'd11,
      LUI      = 5'd12, AUIPC   = 5'd13, EXEC_MUL = 5'd14, MULWB   = 5'd15,
      EXEC_SYS = 5'd16, SYSWB   = 5'd17, TRAP     = 5'd18
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Datapath select codes
   localparam logic [`SRCA-1:0]         SA_PC     = `SRCA'(0);
   localparam logic [`SRCA-1:0]         SA_OLDPC  = `SRCA'(1);
   localparam logic [`SRCA-1:0]         SA_RD1    = `SRCA'(2);
   localparam logic [`SRCA-1:0]         SA_ZERO   = `SRCA'(3);
   localparam logic [`SRCB-1:0]         SB_RD2    = `SRCB'(0);
   localparam logic [`SRCB-1:0]         SB_IMM    = `SRCB'(1);
   localparam logic [`SRCB-1:0]         SB_FOUR   = `SRCB'(2);
   localparam logic [`ALU_OP-1:0]       AOP_ADD   = `ALU_OP'(0);
   localparam logic [`ALU_OP-1:0]       AOP_SUB   = `ALU_OP'(1);
   localparam logic [`ALU_OP-1:0]       AOP_FUNCT = `ALU_OP'(2);
   localparam logic [`RESULT_WIDTH-1:0] RS_ALUOUT = `RESULT_WIDTH'(0);
   localparam logic [`RESULT_WIDTH-1:0] RS_DATA   = `RESULT_WIDTH'(1);
   localparam logic [`RESULT_WIDTH-1:0] RS_ALURES = `RESULT_WIDTH'(2);
   localparam logic [`RESULT_WIDTH-1:0] RS_MULOUT = `RESULT_WIDTH'(3);
   localparam logic [`RESULT_WIDTH-1:0] RS_CSROUT = `RESULT_WIDTH'(4);

   state_t     state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic       mem_valid_c;
   logic       mem_wait;
   logic       wd_expire;

   // A cycle where the bus is being asked and has not answered
   assign mem_wait = (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE)
                     && mem_valid_c && !bus.mem_ready;

   generate
      if (MEM_TIMEOUT > 0) begin : g_wdog
         localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
         logic [WD_W-1:0] wdog;

         // Stall counter; restarts whenever the sequencer moves on
         always_ff @(posedge clk) begin
            if (!resetn)                  wdog <= '0;
            else if (state_d != state_q)  wdog <= '0;
            else if (mem_wait)            wdog <= wdog + 1'b1;
         end

         assign wd_expire = mem_wait && (wdog == WD_W'(MEM_TIMEOUT - 1));
      end else begin : g_no_wdog
         assign wd_expire = 1'b0;
      end
   endgenerate

   // State and trap cause registers; cause is captured only on TRAP entry
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= FETCH;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_d == TRAP && state_q != TRAP) cause_q <= cause_d;
      end
   end

   // Next state and datapath controls
   always_comb begin
      state_d       = state_q;
      cause_d       = 2'b00;
      mem_valid_c   = 1'b0;
      bus.alu_valid = 1'b0;
      bus.mul_valid = 1'b0;
      bus.csr_valid = 1'b0;
      bus.trap_valid = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.PCUpdate  = 1'b0;
      bus.Branch    = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.ALUSrcA   = SA_PC;
      bus.ALUSrcB   = SB_RD2;
      bus.ALUOp     = AOP_ADD;
      bus.ResultSrc = RS_ALUOUT;

      case (state_q)
         FETCH: begin
            mem_valid_c   = 1'b1;
            bus.ALUSrcA   = SA_PC;
            bus.ALUSrcB   = SB_FOUR;
            bus.ResultSrc = RS_ALURES;
            bus.IRWrite   = bus.mem_ready;
            bus.alu_valid = bus.mem_ready;
            bus.PCUpdate  = bus.alu_ready;
            if (bus.mem_ready) state_d = DECODE;
            else if (wd_expire) begin
               state_d = TRAP;
               cause_d = 2'b01;
            end
         end
         DECODE: begin
            // Branch/jal target precomputed into ALUOut
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_OLDPC;
            bus.ALUSrcB   = SB_IMM;
            if (bus.alu_ready) begin
               case (bus.op)
                  OP_LOAD, OP_STORE: state_d = MEMADDR;
                  OP_RTYPE: begin
                     if (!bus.funct7b1) state_d = EXEC_R;
                     else begin
`ifdef KIANV_MULDIV_EN
                        state_d = EXEC_MUL;
`else
                        state_d = TRAP;
                        cause_d = 2'b00;
`endif
                     end
                  end
                  OP_ITYPE:  state_d = EXEC_I;
                  OP_JAL:    state_d = JAL;
                  OP_JALR:   state_d = JALR;
                  OP_BRANCH: state_d = BRANCH;
                  OP_LUI:    state_d = LUI;
                  OP_AUIPC:  state_d = AUIPC;
                  OP_SYSTEM: begin
                     if (CSR_SUPPORT != 0) state_d = EXEC_SYS;
                     else begin
                        state_d = TRAP;
                        cause_d = 2'b00;
                     end
                  end
                  default: begin
                     state_d = TRAP;
                     cause_d = 2'b00;
                  end
               endcase
            end
         end
         MEMADDR: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_RD1;
            bus.ALUSrcB   = SB_IMM;
            if (bus.alu_ready) state_d = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mem_valid_c = 1'b1;
            bus.AdrSrc  = 1'b1;
            if (bus.mem_ready) state_d = MEMWB;
            else if (wd_expire) begin
               state_d = TRAP;
               cause_d = 2'b10;
            end
         end
         MEMWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = RS_DATA;
            state_d       = FETCH;
         end
         MEMWRITE: begin
            mem_valid_c  = 1'b1;
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
            if (bus.mem_ready) state_d = FETCH;
            else if (wd_expire) begin
               state_d = TRAP;
               cause_d = 2'b10;
            end
         end
         EXEC_R: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_RD1;
            bus.ALUSrcB   = SB_RD2;
            bus.ALUOp     = AOP_FUNCT;
            if (bus.alu_ready) state_d = ALUWB;
         end
         EXEC_I: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_RD1;
            bus.ALUSrcB   = SB_IMM;
            bus.ALUOp     = AOP_FUNCT;
            if (bus.alu_ready) state_d = ALUWB;
         end
         ALUWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = RS_ALUOUT;
            state_d       = FETCH;
         end
         JAL: begin
            // PC <- target held in ALUOut while ALU forms the link value
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_OLDPC;
            bus.ALUSrcB   = SB_FOUR;
            bus.ResultSrc = RS_ALUOUT;
            bus.PCUpdate  = bus.alu_ready;
            if (bus.alu_ready) state_d = ALUWB;
         end
         JALR: begin
            // rs1+imm into ALUOut, then reuse JAL for link and PC update
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_RD1;
            bus.ALUSrcB   = SB_IMM;
            if (bus.alu_ready) state_d = JAL;
         end
         BRANCH: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_RD1;
            bus.ALUSrcB   = SB_RD2;
            bus.ALUOp     = AOP_SUB;
            bus.ResultSrc = RS_ALUOUT;
            bus.Branch    = 1'b1;
            mem_valid_c   = bus.Zero;
            if (bus.alu_ready) state_d = FETCH;
         end
         LUI: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_ZERO;
            bus.ALUSrcB   = SB_IMM;
            if (bus.alu_ready) state_d = ALUWB;
         end
         AUIPC: begin
            bus.alu_valid = 1'b1;
            bus.ALUSrcA   = SA_OLDPC;
            bus.ALUSrcB   = SB_IMM;
            if (bus.alu_ready) state_d = ALUWB;
         end
`ifdef KIANV_MULDIV_EN
         EXEC_MUL: begin
            bus.mul_valid = 1'b1;
            if (bus.mul_ready) state_d = MULWB;
         end
         MULWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = RS_MULOUT;
            state_d       = FETCH;
         end
`endif
         EXEC_SYS: begin
            bus.csr_valid = 1'b1;
            if (bus.csr_ready) state_d = SYSWB;
         end
         SYSWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = RS_CSROUT;
            state_d       = FETCH;
         end
         TRAP: begin
            bus.trap_valid = 1'b1;
            if (bus.trap_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.mem_valid   = mem_valid_c;
   assign bus.ALUOutWrite = !mem_valid_c;
   assign bus.trap_cause  = cause_q;

   // Immediate format straight from the opcode: 0 I, 1 S, 2 B, 3 U, 4 J
   always_comb begin
      bus.ImmSrc = 3'd0;
      case (bus.op)
         OP_STORE:         bus.ImmSrc = 3'd1;
         OP_BRANCH:        bus.ImmSrc = 3'd2;
         OP_LUI, OP_AUIPC: bus.ImmSrc = 3'd3;
         OP_JAL:           bus.ImmSrc = 3'd4;
         default:          bus.ImmSrc = 3'd0;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: vector table for the straight-line
// instruction flows, hand sequences for watchdog, trap, mul and reset cases.
module tb_multicycle_ctrl_fsm;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if bus();
   multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .CSR_SUPPORT(1)) dut (
      .clk(clk), .resetn(resetn), .bus(bus));

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011,
                          JALOP = 7'b1101111, BEQ = 7'b1100011, LUIOP = 7'b0110111,
                          SYS = 7'b1110011, BAD = 7'b0000000;

   typedef struct packed {
      logic mv, av, mu, cs, tv, rw, mw, ir, pc, br, ad;
      logic [1:0] sa, sb;
      logic [2:0] rs;
   } obs_t;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic       f7, z, mr, ar, mur, cr, ack;
      obs_t       exp;
   } vec_t;

   vec_t tbl[$];

   function automatic obs_t mk(logic mv, av, mu, cs, tv, rw, mw, ir, pc, br, ad,
                               logic [1:0] sa, logic [1:0] sb, logic [2:0] rs);
      obs_t o;
      o = '{mv, av, mu, cs, tv, rw, mw, ir, pc, br, ad, sa, sb, rs};
      return o;
   endfunction

   // Expected outputs per state (sa: 0 PC 1 OldPC 2 RD1; sb: 0 RD2 1 imm 2 four;
   // rs: 0 ALUOut 1 Data 2 ALURes 3 Mul 4 Csr)
   function automatic obs_t o_fetch(logic mr, logic ar);
      return mk(1, mr, 0, 0, 0, 0, 0, mr, ar, 0, 0, 2'd0, 2'd2, 3'd2);
   endfunction
   function automatic obs_t o_dec();     return mk(0,1,0,0,0,0,0,0,0,0,0, 2'd1, 2'd1, 3'd0); endfunction
   function automatic obs_t o_memaddr(); return mk(0,1,0,0,0,0,0,0,0,0,0, 2'd2, 2'd1, 3'd0); endfunction
   function automatic obs_t o_execr();   return mk(0,1,0,0,0,0,0,0,0,0,0, 2'd2, 2'd0, 3'd0); endfunction
   function automatic obs_t o_aluwb();   return mk(0,0,0,0,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_memread(); return mk(1,0,0,0,0,0,0,0,0,0,1, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_memwb();   return mk(0,0,0,0,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'd1); endfunction
   function automatic obs_t o_memwr();   return mk(1,0,0,0,0,0,1,0,0,0,1, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_trap();    return mk(0,0,0,0,1,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_sys();     return mk(0,0,0,1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_syswb();   return mk(0,0,0,0,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'd4); endfunction
   function automatic obs_t o_mul();     return mk(0,0,1,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0); endfunction
   function automatic obs_t o_mulwb();   return mk(0,0,0,0,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'd3); endfunction
   function automatic obs_t o_branch(logic z);
      return mk(z, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 3'd0);
   endfunction
   function automatic obs_t o_jal(logic ar);
      return mk(0, 1, 0, 0, 0, 0, 0, 0, ar, 0, 0, 2'd1, 2'd2, 3'd0);
   endfunction

   function automatic obs_t sample();
      return mk(bus.mem_valid, bus.alu_valid, bus.mul_valid, bus.csr_valid, bus.trap_valid,
                bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.PCUpdate, bus.Branch, bus.AdrSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc);
   endfunction

   task automatic add(string nm, logic [6:0] op, logic f7, logic z, logic mr, logic ar,
                      logic mur, logic cr, logic ack, obs_t e);
      vec_t v;
      v.name = nm; v.op = op; v.f7 = f7; v.z = z; v.mr = mr; v.ar = ar;
      v.mur = mur; v.cr = cr; v.ack = ack; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic drive(logic [6:0] op, logic f7, logic z, logic mr, logic ar,
                        logic mur, logic cr, logic ack);
      bus.op = op; bus.funct7b1 = f7; bus.Zero = z; bus.mem_ready = mr;
      bus.alu_ready = ar; bus.mul_ready = mur; bus.csr_ready = cr; bus.trap_ack = ack;
   endtask

   task automatic check_obs(string nm, obs_t e);
      obs_t a;
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: outputs got %h expected %h", nm, a, e);
      end
      checks++;
      if (bus.ALUOutWrite !== !e.mv) begin
         errors++;
         $display("FAIL %s ALUOutWrite: got %b expected %b", nm, bus.ALUOutWrite, !e.mv);
      end
   endtask

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: apply inputs away from the edge, check, then let posedge act
   task automatic step(string nm, logic [6:0] op, logic f7, logic z, logic mr, logic ar,
                       logic mur, logic cr, logic ack, obs_t e);
      @(negedge clk);
      drive(op, f7, z, mr, ar, mur, cr, ack);
      #1;
      check_obs(nm, e);
   endtask

   initial begin
      #400000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] imm_ops [5];
      logic [2:0] imm_exp [5];
      imm_ops = '{LW, SW, BEQ, LUIOP, JALOP};
      imm_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

      // add: FETCH DECODE EXEC_R ALUWB
      add("add_fetch",  ADD, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("add_decode", ADD, 0, 0, 1, 1, 0, 0, 0, o_dec());
      add("add_execr",  ADD, 0, 0, 1, 1, 0, 0, 0, o_execr());
      add("add_aluwb",  ADD, 0, 0, 1, 1, 0, 0, 0, o_aluwb());
      // lw with ALU and memory stalls
      add("lw_fetch",   LW, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("lw_decode",  LW, 0, 0, 1, 1, 0, 0, 0, o_dec());
      add("lw_addr_w0", LW, 0, 0, 1, 0, 0, 0, 0, o_memaddr());
      add("lw_addr_w1", LW, 0, 0, 1, 0, 0, 0, 0, o_memaddr());
      add("lw_addr",    LW, 0, 0, 1, 1, 0, 0, 0, o_memaddr());
      add("lw_rd_w0",   LW, 0, 0, 0, 1, 0, 0, 0, o_memread());
      add("lw_rd_w1",   LW, 0, 0, 0, 1, 0, 0, 0, o_memread());
      add("lw_rd_w2",   LW, 0, 0, 0, 1, 0, 0, 0, o_memread());
      add("lw_rd",      LW, 0, 0, 1, 1, 0, 0, 0, o_memread());
      add("lw_memwb",   LW, 0, 0, 1, 1, 0, 0, 0, o_memwb());
      // csr system op
      add("sys_fetch",  SYS, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("sys_decode", SYS, 0, 0, 1, 1, 0, 0, 0, o_dec());
      add("sys_wait",   SYS, 0, 0, 1, 1, 0, 0, 0, o_sys());
      add("sys_exec",   SYS, 0, 0, 1, 1, 0, 1, 0, o_sys());
      add("sys_wb",     SYS, 0, 0, 1, 1, 0, 0, 0, o_syswb());
      // branch: mem_valid follows Zero
      add("beq_fetch",  BEQ, 0, 1, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("beq_decode", BEQ, 0, 1, 1, 1, 0, 0, 0, o_dec());
      add("beq_wait_z", BEQ, 0, 1, 1, 0, 0, 0, 0, o_branch(1));
      add("beq_nz",     BEQ, 0, 0, 1, 1, 0, 0, 0, o_branch(0));
      // jal
      add("jal_fetch",  JALOP, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("jal_decode", JALOP, 0, 0, 1, 1, 0, 0, 0, o_dec());
      add("jal_wait",   JALOP, 0, 0, 1, 0, 0, 0, 0, o_jal(0));
      add("jal_exec",   JALOP, 0, 0, 1, 1, 0, 0, 0, o_jal(1));
      add("jal_wb",     JALOP, 0, 0, 1, 1, 0, 0, 0, o_aluwb());
      // illegal opcode, trap held until ack
      add("ill_fetch",  BAD, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      add("ill_decode", BAD, 0, 0, 1, 1, 0, 0, 0, o_dec());
      for (int i = 0; i < 5; i++)
         add("ill_trap_hold", BAD, 0, 0, 1, 1, 0, 0, 0, o_trap());
      add("ill_trap_ack", BAD, 0, 0, 1, 1, 0, 0, 1, o_trap());

      // Reset state
      drive(ADD, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check_obs("reset_fetch", o_fetch(0, 0));
      chk("reset_cause", {6'd0, bus.trap_cause}, 8'd0);
      for (int i = 0; i < 5; i++) begin
         bus.op = imm_ops[i];
         #1;
         chk("immsrc", {5'd0, bus.ImmSrc}, {5'd0, imm_exp[i]});
      end
      bus.op = ADD;
      resetn = 1'b1;

      foreach (tbl[i])
         step(tbl[i].name, tbl[i].op, tbl[i].f7, tbl[i].z, tbl[i].mr, tbl[i].ar,
              tbl[i].mur, tbl[i].cr, tbl[i].ack, tbl[i].exp);
      #1;
      chk("ill_cause", {6'd0, bus.trap_cause}, 8'd0);

      // Fetch watchdog: 4 stall cycles -> TRAP cause 01
      for (int i = 0; i < 4; i++) step("wd_fetch_stall", ADD, 0, 0, 0, 0, 0, 0, 0, o_fetch(0, 0));
      step("wd_fetch_trap", ADD, 0, 0, 0, 0, 0, 0, 0, o_trap());
      chk("wd_fetch_cause", {6'd0, bus.trap_cause}, 8'd1);
      step("wd_fetch_ack", ADD, 0, 0, 0, 0, 0, 0, 1, o_trap());
      // Ready on the last allowed cycle wins
      for (int i = 0; i < 3; i++) step("wd_edge_stall", LW, 0, 0, 0, 0, 0, 0, 0, o_fetch(0, 0));
      step("wd_edge_ready", LW, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      step("wd_edge_decode", LW, 0, 0, 1, 1, 0, 0, 0, o_dec());
      step("wd_rd_addr", LW, 0, 0, 1, 1, 0, 0, 0, o_memaddr());
      for (int i = 0; i < 4; i++) step("wd_rd_stall", LW, 0, 0, 0, 0, 0, 0, 0, o_memread());
      step("wd_rd_trap", LW, 0, 0, 0, 0, 0, 0, 1, o_trap());
      chk("wd_rd_cause", {6'd0, bus.trap_cause}, 8'd2);

      // Multiply: M path or illegal depending on build
      step("mul_fetch", ADD, 1, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      step("mul_decode", ADD, 1, 0, 1, 1, 0, 0, 0, o_dec());
`ifdef KIANV_MULDIV_EN
      for (int i = 0; i < 9; i++) step("mul_wait", ADD, 1, 0, 1, 1, 0, 0, 0, o_mul());
      step("mul_done", ADD, 1, 0, 1, 1, 1, 0, 0, o_mul());
      step("mul_wb", ADD, 1, 0, 1, 1, 0, 0, 0, o_mulwb());
`else
      step("mul_trap", ADD, 1, 0, 1, 1, 0, 0, 0, o_trap());
      chk("mul_cause", {6'd0, bus.trap_cause}, 8'd0);
      step("mul_ack", ADD, 1, 0, 1, 1, 0, 0, 1, o_trap());
`endif

      // Reset during a stalled store
      step("sw_fetch", SW, 0, 0, 1, 1, 0, 0, 0, o_fetch(1, 1));
      step("sw_decode", SW, 0, 0, 1, 1, 0, 0, 0, o_dec());
      step("sw_addr", SW, 0, 0, 1, 1, 0, 0, 0, o_memaddr());
      step("sw_stall0", SW, 0, 0, 0, 0, 0, 0, 0, o_memwr());
      step("sw_stall1", SW, 0, 0, 0, 0, 0, 0, 0, o_memwr());
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_obs("rst_fetch", o_fetch(0, 0));
      chk("rst_cause", {6'd0, bus.trap_cause}, 8'd0);
      // Cleared watchdog needs the full 4 stalls again
      for (int i = 0; i < 3; i++) step("rst_wd_stall", SW, 0, 0, 0, 0, 0, 0, 0, o_fetch(0, 0));
      step("rst_wd_trap", SW, 0, 0, 0, 0, 0, 0, 1, o_trap());
      chk("rst_wd_cause", {6'd0, bus.trap_cause}, 8'd1);
      step("rst_wd_back", SW, 0, 0, 0, 0, 0, 0, 0, o_fetch(0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
